// File: rtl/uart_wb_if.sv
// Register-port bundle between the SoC bus master and uart_wb.
interface uart_wb_if;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_in;
  logic [7:0] wb_data_out;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack;

  modport master (output wb_addr, wb_data_in, wb_we, wb_stb, input wb_data_out, wb_ack);
  modport slave  (input wb_addr, wb_data_in, wb_we, wb_stb, output wb_data_out, wb_ack);
endinterface

// File: rtl/uart_wb.sv
// 8N1 UART with TX/RX byte FIFOs behind a 4-register bus port.
// wb_we is 1 for reads and 0 for writes.
module uart_wb #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_wb_if.slave bus,
  output logic     tx_bit,
  input  logic     rx_bit,
  output logic     probe0
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic          access_c, rd_c, wr_c;
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [NW-1:0] tx_cnt;
  logic          tx_full_c, tx_push_c, tx_load_c, tx_last_c, tx_busy_c;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [NW-1:0] rx_cnt;
  logic          rx_full_c, rx_push_c, rx_pop_c, rx_done_c, rx_last_c, rx_ovr_set_c;
  logic          overrun;
  logic [7:0]    status_c;

  uart_state_e   tx_state, tx_state_n;
  logic [CW-1:0] tx_clk, tx_clk_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_bit_n;

  uart_state_e   rx_state, rx_state_n;
  logic [CW-1:0] rx_clk, rx_clk_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_meta, rx_sync, rx_prev;

  // An access executes once per strobe; ack blocks the cycle right after.
  assign access_c = bus.wb_stb && !bus.wb_ack;
  assign rd_c     = access_c && bus.wb_we;
  assign wr_c     = access_c && !bus.wb_we;

  assign tx_full_c = (tx_cnt == NW'(FIFO_DEPTH));
  assign rx_full_c = (rx_cnt == NW'(FIFO_DEPTH));
  assign tx_last_c = (tx_clk == CW'(CLKS_PER_BIT - 1));
  assign rx_last_c = (rx_clk == CW'(CLKS_PER_BIT - 1));
  assign tx_load_c = (tx_cnt != '0) && ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_last_c));
  assign tx_push_c = wr_c && (bus.wb_addr == 2'd0) && (!tx_full_c || tx_load_c);
  assign rx_pop_c  = rd_c && (bus.wb_addr == 2'd1) && (rx_cnt != '0);
  assign rx_push_c = rx_done_c && (!rx_full_c || rx_pop_c);
  assign rx_ovr_set_c = rx_done_c && rx_full_c && !rx_pop_c;
  assign tx_busy_c = (tx_state != S_IDLE) || (tx_cnt != '0);
  assign status_c  = {4'b0000, overrun, tx_busy_c, tx_full_c, rx_cnt != '0};

  // FIFO pointers and counts; a same-cycle push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      tx_wp  <= tx_wp + AW'(tx_push_c);
      tx_rp  <= tx_rp + AW'(tx_load_c);
      tx_cnt <= tx_cnt + NW'(tx_push_c) - NW'(tx_load_c);
      rx_wp  <= rx_wp + AW'(rx_push_c);
      rx_rp  <= rx_rp + AW'(rx_pop_c);
      rx_cnt <= rx_cnt + NW'(rx_push_c) - NW'(rx_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push_c) tx_mem[tx_wp] <= bus.wb_data_in;
    if (rx_push_c) rx_mem[rx_wp] <= rx_shift;
  end

  // Bus response; the overrun set wins over a same-cycle STATUS clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.wb_ack      <= 1'b0;
      bus.wb_data_out <= 8'h00;
      overrun         <= 1'b0;
    end else begin
      bus.wb_ack <= access_c;
      if (rd_c) begin
        case (bus.wb_addr)
          2'd1:    bus.wb_data_out <= rx_pop_c ? rx_mem[rx_rp] : 8'h00;
          2'd2:    bus.wb_data_out <= status_c;
          default: bus.wb_data_out <= 8'h00;
        endcase
      end
      if (rd_c && (bus.wb_addr == 2'd2)) overrun <= 1'b0;
      if (rx_ovr_set_c) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_clk   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_bit   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_clk   <= tx_clk_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
    end
  end

  // TX sequencing; a pending byte is loaded straight out of the stop bit.
  always_comb begin
    tx_state_n = tx_state;
    tx_clk_n   = tx_clk + CW'(1);
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    case (tx_state)
      S_IDLE: begin
        tx_clk_n = '0;
        tx_bit_n = 1'b1;
      end
      S_START: if (tx_last_c) begin
        tx_state_n = S_DATA;
        tx_clk_n   = '0;
        tx_idx_n   = '0;
        tx_bit_n   = tx_shift[0];
        tx_shift_n = {1'b0, tx_shift[7:1]};
      end
      S_DATA: if (tx_last_c) begin
        tx_clk_n = '0;
        if (tx_idx == 3'd7) begin
          tx_state_n = S_STOP;
          tx_bit_n   = 1'b1;
        end else begin
          tx_idx_n   = tx_idx + 3'd1;
          tx_bit_n   = tx_shift[0];
          tx_shift_n = {1'b0, tx_shift[7:1]};
        end
      end
      S_STOP: if (tx_last_c) begin
        tx_state_n = S_IDLE;
        tx_clk_n   = '0;
      end
    endcase
    if (tx_load_c) begin
      tx_state_n = S_START;
      tx_clk_n   = '0;
      tx_bit_n   = 1'b0;
      tx_shift_n = tx_mem[tx_rp];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_clk   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      probe0   <= 1'b0;
    end else begin
      rx_meta  <= rx_bit;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_clk   <= rx_clk_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      probe0   <= (rx_state_n != S_IDLE);
    end
  end

  // RX sampling: half a bit to the start-bit midpoint, then one bit per sample.
  always_comb begin
    rx_state_n = rx_state;
    rx_clk_n   = rx_clk + CW'(1);
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_done_c  = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_clk_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = S_START;
      end
      S_START: if (rx_clk == CW'(CLKS_PER_BIT / 2 - 1)) begin
        rx_clk_n   = '0;
        rx_idx_n   = '0;
        rx_state_n = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_last_c) begin
        rx_clk_n   = '0;
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        if (rx_idx == 3'd7) rx_state_n = S_STOP;
        else                rx_idx_n   = rx_idx + 3'd1;
      end
      S_STOP: if (rx_last_c) begin
        rx_state_n = S_IDLE;
        rx_clk_n   = '0;
        rx_done_c  = rx_sync;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_wb.sv
// Directed/randomized bench for uart_wb with a queue-based model of the RX FIFO
// and a frame-level expected waveform for TX.
module tb_uart_wb;
  localparam int CPB   = 50;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_line = 1'b1;
  logic tx_bit, probe0;
  int total = 0;
  int bad = 0;

  logic [7:0] rx_model[$];
  logic       model_ovr = 1'b0;
  logic [7:0] tx_exp[$];

  uart_wb_if bus_if ();

  uart_wb #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .tx_bit (tx_bit),
    .rx_bit (rx_line),
    .probe0 (probe0)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus access; ack must arrive exactly one cycle after the request.
  task automatic access(input logic rd, input logic [1:0] addr, input logic [7:0] din,
                        output logic [7:0] dout);
    int n;
    @(negedge clk);
    bus_if.wb_we      = rd;
    bus_if.wb_addr    = addr;
    bus_if.wb_data_in = din;
    bus_if.wb_stb     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.wb_ack !== 1'b1 && n < 8);
    check("ack_latency", n, 1);
    dout = bus_if.wb_data_out;
    bus_if.wb_stb = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", bus_if.wb_ack, 1'b0);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] din);
    logic [7:0] unused;
    access(1'b0, addr, din, unused);
  endtask

  task automatic rd(input logic [1:0] addr, output logic [7:0] dout);
    access(1'b1, addr, 8'h00, dout);
  endtask

  function automatic logic [7:0] model_pop();
    if (rx_model.size() != 0) return rx_model.pop_front();
    return 8'h00;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (rx_model.size() < DEPTH) rx_model.push_back(b);
    else model_ovr = 1'b1;
  endfunction

  task automatic rd_status(input string tag, input logic busy, input logic full);
    logic [7:0] d;
    logic [7:0] exp;
    exp = {4'b0000, model_ovr, busy, full, rx_model.size() != 0};
    rd(2'd2, d);
    check(tag, d, exp);
    model_ovr = 1'b0;
  endtask

  task automatic rd_rx(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    exp = model_pop();
    rd(2'd1, d);
    check(tag, d, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int cpb);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_line = f[k];
      repeat (cpb) @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  // Compares tx_bit cycle by cycle against the frames in tx_exp, sent back to back.
  task automatic check_tx();
    int n, errs, idle_errs;
    logic [9:0] frame;
    n = 0;
    while (tx_bit !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", tx_bit, 1'b0);
    errs = 0;
    foreach (tx_exp[i]) begin
      frame = {1'b1, tx_exp[i], 1'b0};
      for (int k = 0; k < 10 * CPB; k++) begin
        if (tx_bit !== frame[k / CPB]) errs++;
        @(negedge clk);
      end
    end
    check("tx_wave", errs, 0);
    idle_errs = 0;
    for (int k = 0; k < 2 * CPB; k++) begin
      if (tx_bit !== 1'b1) idle_errs++;
      @(negedge clk);
    end
    check("tx_idle_after", idle_errs, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] bytes [DEPTH+2];
    bus_if.wb_addr    = 2'd0;
    bus_if.wb_data_in = 8'h00;
    bus_if.wb_we      = 1'b0;
    bus_if.wb_stb     = 1'b0;

    repeat (4) @(negedge clk);
    check("rst_tx_bit", tx_bit, 1'b1);
    check("rst_ack", bus_if.wb_ack, 1'b0);
    check("rst_dout", bus_if.wb_data_out, 8'h00);
    check("rst_probe0", probe0, 1'b0);
    reset = 1'b1;
    rd_status("rst_status", 1'b0, 1'b0);

    // Two frames at 2% fast baud.
    fork
      begin
        send_rx(8'h55, 1'b1, CPB - 1);
        repeat (3 * CPB) @(negedge clk);
        send_rx(8'h7F, 1'b1, CPB - 1);
      end
      begin
        repeat (2 * CPB) @(negedge clk);
        check("probe0_active", probe0, 1'b1);
      end
    join
    model_push(8'h55);
    model_push(8'h7F);
    repeat (CPB) @(negedge clk);
    check("probe0_idle", probe0, 1'b0);
    rd_rx("rx_first");
    rd_rx("rx_second");
    rd_rx("rx_empty");
    rd_status("status_rx_empty", 1'b0, 1'b0);

    tx_exp.delete();
    tx_exp.push_back(8'h42);
    fork
      check_tx();
      begin
        wr(2'd0, 8'h42);
        repeat (3 * CPB) @(negedge clk);
        rd_status("status_tx_busy", 1'b1, 1'b0);
      end
    join
    rd_status("status_tx_done", 1'b0, 1'b0);
    rd(2'd0, d);
    check("txdata_reads_zero", d, 8'h00);
    wr(2'd3, 8'hA5);
    rd(2'd3, d);
    check("reserved_reads_zero", d, 8'h00);

    // Short low glitch, then a frame with a bad stop bit.
    rx_line = 1'b0;
    repeat (CPB / 5) @(negedge clk);
    rx_line = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    rd_status("status_after_glitch", 1'b0, 1'b0);
    b = 8'($urandom);
    send_rx(b, 1'b0, CPB);
    repeat (2 * CPB) @(negedge clk);
    rd_status("status_after_framing", 1'b0, 1'b0);
    rd_rx("rx_after_framing");

    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1, int'($urandom_range(CPB + 1, CPB - 1)));
      model_push(b);
      repeat (CPB) @(negedge clk);
      rd_rx("rx_random");
    end

    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1, CPB);
      model_push(b);
    end
    repeat (CPB) @(negedge clk);
    rd_status("status_overrun_set", 1'b0, 1'b0);
    rd_status("status_overrun_clr", 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) rd_rx("rx_overrun_order");
    rd_status("status_overrun_drained", 1'b0, 1'b0);

    // One byte goes straight to the shifter, DEPTH fill the FIFO, the last is dropped.
    for (int i = 0; i < DEPTH + 2; i++) bytes[i] = 8'($urandom);
    tx_exp.delete();
    for (int i = 0; i < DEPTH + 1; i++) tx_exp.push_back(bytes[i]);
    fork
      check_tx();
      begin
        for (int i = 0; i < DEPTH + 2; i++) begin
          if (i == DEPTH + 1) rd_status("status_tx_full", 1'b1, 1'b1);
          wr(2'd0, bytes[i]);
        end
      end
    join
    rd_status("status_tx_drained", 1'b0, 1'b0);

    // Reset in the middle of a frame.
    wr(2'd0, 8'h00);
    repeat (3 * CPB) @(negedge clk);
    check("tx_mid_frame", tx_bit, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("tx_abort", tx_bit, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("tx_idle_after_reset", tx_bit, 1'b1);
    rd_status("status_after_reset", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
